// File: rtl/bist_mul_controller.sv
// BIST controller for a 4x4 multiplier: LFSR operand generation, MISR compaction, golden compare.
// Optional functional bypass ports enabled by defining BIST_MUL_BYPASS_EN.
module bist_mul_controller #(
  parameter int unsigned PATTERNS   = 255,
  parameter int unsigned LATENCY    = 2,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  output logic       mul_rst,
  input  logic [7:0] mul_result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
`ifdef BIST_MUL_BYPASS_EN
  ,
  input  logic [3:0] func_a,
  input  logic [3:0] func_b,
  output logic [7:0] func_result
`endif
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned SIG_W = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CUT_RST = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] CUT_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(PATTERNS + LATENCY - 1);
  localparam logic [CNT_W:0]   FILL_LEN = (CNT_W + 1)'(LATENCY);
  localparam logic [SIG_W-1:0] SEED     = 8'h01;

  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SIG_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [SIG_W-1:0] r_sig, w_sig_nxt;
  logic [OP_W-1:0]  r_mul_a, w_a_nxt;
  logic [OP_W-1:0]  r_mul_b, w_b_nxt;
  logic             r_mul_rst, w_mul_rst_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_sample;

  // Result is compressed only once the first operand has propagated through the multiplier.
  assign w_sample = ((CNT_W + 1)'(r_cnt) + (CNT_W + 1)'(1)) > FILL_LEN;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lfsr_nxt    = r_lfsr;
    w_sig_nxt     = r_sig;
    w_mul_rst_nxt = 1'b0;
    w_pass_nxt    = r_pass;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_CUT_RST;
          w_cnt_nxt   = '0;
          w_lfsr_nxt  = SEED;
          w_sig_nxt   = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_CUT_RST: begin
        // First cycle sets up, then the multiplier reset is held for two cycles.
        if (r_cnt == CUT_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt     = r_cnt + CNT_W'(1);
          w_mul_rst_nxt = 1'b1;
        end
      end
      S_RUN: begin
        w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        if (w_sample) begin
          w_sig_nxt = {r_sig[6:0], r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3]} ^ mul_result;
        end
        if (r_cnt == RUN_LAST) begin
          w_state_nxt = S_COMPARE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_COMPARE: begin
        w_pass_nxt  = (r_sig == GOLDEN_SIG);
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_a_nxt = w_lfsr_nxt[7:4];
    w_b_nxt = w_lfsr_nxt[3:0];
    if (w_state_nxt == S_IDLE) begin
`ifdef BIST_MUL_BYPASS_EN
      w_a_nxt = func_a;
      w_b_nxt = func_b;
`else
      w_a_nxt = '0;
      w_b_nxt = '0;
`endif
    end else if (w_state_nxt == S_DONE) begin
`ifdef BIST_MUL_BYPASS_EN
      w_a_nxt = func_a;
      w_b_nxt = func_b;
`else
      w_a_nxt = r_mul_a;
      w_b_nxt = r_mul_b;
`endif
    end

    w_busy_nxt = (w_state_nxt == S_CUT_RST) || (w_state_nxt == S_RUN) ||
                 (w_state_nxt == S_COMPARE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lfsr    <= SEED;
      r_sig     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_sig     <= w_sig_nxt;
      r_mul_a   <= w_a_nxt;
      r_mul_b   <= w_b_nxt;
      r_mul_rst <= w_mul_rst_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_rst   = r_mul_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

`ifdef BIST_MUL_BYPASS_EN
  assign func_result = mul_result;
`endif

endmodule

// File: tb/tb_bist_mul_controller.sv
// Scoreboard bench for bist_mul_controller: two instances (P=4/L=1 passing, P=255/L=0 failing golden).
module tb_bist_mul_controller;

  localparam int unsigned PA = 4;
  localparam int unsigned LA = 1;
  localparam int unsigned PB = 255;
  localparam int unsigned LB = 0;

  // Reference: signature of the first p LFSR patterns multiplied and folded into the MISR.
  function automatic logic [7:0] ref_sig(input int unsigned p);
    logic [7:0] q, s, prod;
    q = 8'h01;
    s = 8'h00;
    for (int unsigned i = 0; i < p; i++) begin
      prod = 8'(q[7:4]) * 8'(q[3:0]);
      s    = {s[6:0], ^(s & 8'hB8)} ^ prod;
      q    = {q[6:0], ^(q & 8'hB8)};
    end
    return s;
  endfunction

  function automatic logic [7:0] ref_op(input int unsigned k);
    logic [7:0] q;
    q = 8'h01;
    for (int unsigned i = 0; i < k; i++) q = {q[6:0], ^(q & 8'hB8)};
    return q;
  endfunction

  localparam logic [7:0] SIG_A = ref_sig(PA);
  localparam logic [7:0] SIG_B = ref_sig(PB);

  typedef struct {
    int unsigned at_edge;
    logic [7:0]  sig;
    logic        pass;
  } exp_t;

  logic clk, rst, start;
  logic [3:0] a_a, b_a, a_b, b_b;
  logic mr_a, mr_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] res_a, res_b, sig_a, sig_b;
`ifdef BIST_MUL_BYPASS_EN
  logic [3:0] func_a, func_b;
  logic [7:0] fres_a, fres_b;
`endif

  int unsigned cyc, n_cmp, n_bad, till_a, till_b;
  exp_t q_a[$], q_b[$];
  logic pd_a, pd_b;

  bist_mul_controller #(.PATTERNS(PA), .LATENCY(LA), .GOLDEN_SIG(SIG_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .mul_a(a_a), .mul_b(b_a), .mul_rst(mr_a),
    .mul_result(res_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
`ifdef BIST_MUL_BYPASS_EN
    , .func_a(func_a), .func_b(func_b), .func_result(fres_a)
`endif
  );

  bist_mul_controller #(.PATTERNS(PB), .LATENCY(LB), .GOLDEN_SIG(SIG_B ^ 8'h01)) u_b (
    .clk(clk), .rst(rst), .start(start), .mul_a(a_b), .mul_b(b_b), .mul_rst(mr_b),
    .mul_result(res_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
`ifdef BIST_MUL_BYPASS_EN
    , .func_a(func_a), .func_b(func_b), .func_result(fres_b)
`endif
  );

  // Multiplier models: one pipeline stage for u_a, purely combinational for u_b.
  always @(posedge clk) res_a <= mr_a ? 8'h00 : 8'(a_a) * 8'(b_a);
  assign res_b = 8'(a_b) * 8'(b_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive start for one cycle from a negedge; model acceptance per instance.
  task automatic step(input logic s);
    start = s;
    if (s) begin
      if (cyc + 1 > till_a) begin
        till_a = cyc + 1 + PA + LA + 4;
        q_a.push_back('{till_a, SIG_A, 1'b1});
      end
      if (cyc + 1 > till_b) begin
        till_b = cyc + 1 + PB + LB + 4;
        q_b.push_back('{till_b, SIG_B, 1'b0});
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    till_a = 0;
    till_b = 0;
  endtask

  // Monitors: each rising done pops one expected run result.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done_a && !pd_a) begin
      check("a_done_queued", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_done_edge", cyc, e.at_edge);
        check("a_signature", 32'(sig_a), 32'(e.sig));
        check("a_pass", 32'(pass_a), 32'(e.pass));
      end
    end
    if (rst && done_b && !pd_b) begin
      check("b_done_queued", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_done_edge", cyc, e.at_edge);
        check("b_signature", 32'(sig_b), 32'(e.sig));
        check("b_pass", 32'(pass_b), 32'(e.pass));
      end
    end
    pd_a = done_a;
    pd_b = done_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       tr_rst[12];
    logic [7:0] tr_op[12];
    int         highs, last_high;
    logic [7:0] exp_op;
    cyc = 0; n_cmp = 0; n_bad = 0; pd_a = 0; pd_b = 0;
    clear_model();
    rst = 1'b0;
    start = 1'b0;
`ifdef BIST_MUL_BYPASS_EN
    func_a = 4'hA;
    func_b = 4'h2;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_mul_rst", 32'(mr_a), 0);
    check("rst_ops", 32'({a_a, b_a}), 0);
    check("rst_sig", 32'(sig_b), 0);

    // Start sampled in the first cycle after reset release.
    rst = 1'b1;
    step(1'b1);
    check("busy_after_start", 32'(busy_a), 1);
    for (int i = 0; i < 12; i++) begin
      tr_rst[i] = mr_a;
      tr_op[i]  = {a_a, b_a};
      @(negedge clk);
    end
    highs = 0;
    last_high = 0;
    for (int i = 0; i < 12; i++) if (tr_rst[i]) begin highs++; last_high = i; end
    check("mul_rst_cycles", 32'(highs), 2);
    for (int k = 0; k < 5; k++) begin
      exp_op = ref_op(k);
      check("run_operands", 32'(tr_op[last_high + 1 + k]), 32'(exp_op));
    end

    // Start in DONE clears done/pass and begins a new run.
    while (cyc <= till_a + 1) @(negedge clk);
    check("done_held", 32'(done_a), 1);
    step(1'b1);
    check("restart_done", 32'(done_a), 0);
    check("restart_pass", 32'(pass_a), 0);
    check("restart_busy", 32'(busy_a), 1);
    repeat (4) step(1'b0);
    step(1'b1);

    // Long run: LFSR wraps to the seed after 255 patterns.
    while (cyc <= till_b + 1) @(negedge clk);
`ifndef BIST_MUL_BYPASS_EN
    check("b_ops_wrapped", 32'({a_b, b_b}), 32'h01);
`endif

    // Asynchronous reset in the middle of RUN.
    step(1'b1);
    repeat (5) step(1'b0);
    #2 rst = 1'b0;
    clear_model();
    #1;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    check("abort_pass", 32'(pass_a), 0);
    check("abort_mul_rst", 32'(mr_a), 0);
    check("abort_ops", 32'({a_a, b_a}), 0);
    check("abort_sig", 32'(sig_a), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) step(1'b0);
    check("idle_busy", 32'(busy_a), 0);
    check("idle_done", 32'(done_a), 0);
`ifdef BIST_MUL_BYPASS_EN
    check("bypass_ops", 32'({a_a, b_a}), 32'hA2);
    check("bypass_result", 32'(fres_a), 32'h14);
`endif

    // Random start pulses with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        clear_model();
        @(negedge clk);
        rst = 1'b1;
      end else begin
        step($urandom_range(0, 5) == 0);
      end
    end

    while (cyc <= till_a + 2 || cyc <= till_b + 2) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 0);
    check("b_queue_drained", 32'(q_b.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_mul_controller.md
BIST_MUL_CONTROLLER -- requirements
Module: bist_mul_controller

Interface
REQ-001 Parameter PATTERNS, 255: number of LFSR operand patterns applied per run; legal range 1..255.
REQ-002 Parameter LATENCY, 2: clock cycles from operands applied to a valid multiplier result; legal range 0..7.
REQ-003 Parameter GOLDEN_SIG, 8'h00: expected final MISR signature.
REQ-004 clk  in  1  single clock; all flops rise-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a self-test run.
REQ-007 mul_a  out  4  multiplier operand a.
REQ-008 mul_b  out  4  multiplier operand b.
REQ-009 mul_rst  out  1  active-high reset to the multiplier.
REQ-010 mul_result  in  8  multiplier final_result.
REQ-011 busy  out  1  high while a run is in progress.
REQ-012 done  out  1  high from run completion until the next accepted start.
REQ-013 pass  out  1  valid while done=1; 1 = signature matched GOLDEN_SIG.
REQ-014 signature  out  8  current MISR value.

Function
REQ-015 FSM states: IDLE, CUT_RST, RUN, COMPARE, DONE; all outputs registered.
REQ-016 IDLE/DONE: start=1 -> CUT_RST; done, pass cleared; LFSR loaded to 8'h01; MISR loaded to 8'h00; busy=1 from the next cycle.
REQ-017 Start while busy=1 is ignored.
REQ-018 CUT_RST: mul_rst=1 for exactly 2 cycles, then RUN; mul_rst=0 in every other state.
REQ-019 LFSR: 8-bit, next = {q[6:0], q[7]^q[5]^q[4]^q[3]}; mul_a=q[7:4], mul_b=q[3:0]; advances once per RUN cycle.
REQ-020 Operand sequence from seed: 8'h01, 8'h02, 8'h04, 8'h08, 8'h11, ...; period 255, never 8'h00.
REQ-021 RUN lasts PATTERNS+LATENCY cycles, tracked by a 9-bit cycle counter starting at 0.
REQ-022 MISR update enabled when counter >= LATENCY: sig <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ mul_result; exactly PATTERNS samples are compressed.
REQ-023 LFSR continues advancing during the LATENCY drain cycles; those operands are never compressed.
REQ-024 COMPARE: one cycle; pass <= (signature == GOLDEN_SIG); then DONE.
REQ-025 DONE: done=1, busy=0, operands held, signature held; remains until next start.
REQ-026 With PATTERNS=P and LATENCY=L, done rises on the (P+L+4)th rising edge after the edge that samples start.
REQ-027 IDLE: mul_a=mul_b=0 unless REQ-033 applies.

Reset
REQ-028 rst=0 asynchronously forces state IDLE, busy=0, done=0, pass=0, mul_rst=0, mul_a=0, mul_b=0, LFSR=8'h01, MISR=8'h00, counter=0.
REQ-029 Reset mid-run aborts the run; after release the block stays in IDLE until a new start.
REQ-030 start sampled high in the first cycle after rst release is accepted normally.

Configuration
REQ-031 Macro BIST_MUL_BYPASS_EN adds ports func_a (in, 4), func_b (in, 4) and func_result (out, 8).
REQ-032 With the macro defined, func_result = mul_result combinationally in all states.
REQ-033 With the macro defined, in IDLE and DONE: mul_a=func_a, mul_b=func_b; in CUT_RST/RUN/COMPARE the LFSR drives operands.
REQ-034 Without the macro, the functional ports do not exist and operands follow REQ-019/REQ-025/REQ-027 only.

Verification
REQ-035 Assert rst=0 mid-RUN -> busy, done, pass, mul_rst, mul_a and mul_b all 0 immediately (no clock edge); after release the block idles until start.
REQ-036 start pulse, PATTERNS=4, LATENCY=1 -> mul_rst=1 for 2 cycles; then mul_a/mul_b = 0/1, 0/2, 0/4, 0/8, 1/1 on consecutive cycles.
REQ-037 PATTERNS=4, LATENCY=1 with a real multiplier, GOLDEN_SIG from a reference model -> done=1 on the 9th edge after start, pass=1; GOLDEN_SIG^8'h01 -> pass=0.
REQ-038 start pulsed at cycle 5 of a run -> run timing unchanged; start in DONE -> done=0 and pass=0 next cycle, new run begins.
REQ-039 BIST_MUL_BYPASS_EN, IDLE, func_a=4'hA, func_b=4'h2 -> mul_a=4'hA, mul_b=4'h2; func_result=8'h14 once the multiplier result is valid.
REQ-040 PATTERNS=255, LATENCY=0 -> LFSR returns to 8'h01 after 255 RUN cycles; done asserts on the 259th edge after start.
